// File: rtl/arrmul_pkg.sv
// Shared definitions for the pipelined signed/unsigned array multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   MODE_UNSIGNED / MODE_SIGNED : encodings of the per-operation mode bit
//   stages(width, rows)         : number of compute stages, ceil(width/rows)
package arrmul_pkg;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

  function automatic int stages(input int width, input int rows);
    return (width + rows - 1) / rows;
  endfunction

endpackage

// File: rtl/arrmul_row.sv
// One combinational row of the array: WIDTH partial-product gates plus a ripple adder.
// Latency: combinational.
// Backpressure: none (pure logic, the enclosing pipeline stalls around it).
//
// Ports:
//   a_i           multiplicand
//   b_i           the multiplier bit owned by this row
//   signed_i      operation mode (MODE_SIGNED selects Baugh-Wooley gating)
//   is_last_row_i high for the row of multiplier bit WIDTH-1
//   sum_i         running partial sum, bit 0 aligned to this row's column
//   sum_o         running partial sum, bit 0 aligned to the next row's column
//   pbit_o        finished product bit for this row's column
module arrmul_row
  import arrmul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic             b_i,
  input  logic             signed_i,
  input  logic             is_last_row_i,
  input  logic [WIDTH:0]   sum_i,
  output logic [WIDTH:0]   sum_o,
  output logic             pbit_o
);

  logic [WIDTH:0]   pp;
  logic [WIDTH+1:0] t;
  logic             c;

  always_comb begin
    pp = '0;
    t  = '0;
    c  = 1'b0;
    // Baugh-Wooley: a cross term involving exactly one operand MSB is complemented.
    for (int i = 0; i < WIDTH; i++) begin
      pp[i] = a_i[i] & b_i;
      if ((signed_i == MODE_SIGNED) && (is_last_row_i != (i == WIDTH - 1))) begin
        pp[i] = ~pp[i];
      end
    end
    // Full-adder ripple; the top position only absorbs the carry from the row above.
    for (int i = 0; i <= WIDTH; i++) begin
      t[i] = sum_i[i] ^ pp[i] ^ c;
      c    = (sum_i[i] & pp[i]) | (c & (sum_i[i] ^ pp[i]));
    end
    t[WIDTH+1] = c;
  end

  assign pbit_o = t[0];
  assign sum_o  = t[WIDTH+1:1];

endmodule

// File: rtl/pipe_s_u_arrmul.sv
// Pipelined array multiplier, signed (Baugh-Wooley) or unsigned chosen per operation.
// Latency: op accepted at edge k appears on out_* after edge k+STAGES.
// Backpressure: global stall, in_ready = !out_valid | out_ready; all stages hold when low.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready          operand handshake; in_a, in_b, in_signed, in_tag ride with it
//   out_valid/out_ready        product handshake; out_prod (2*WIDTH), out_tag
module pipe_s_u_arrmul
  import arrmul_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int ROWS_PER_STAGE = 2,
  parameter int TAG_W          = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int STAGES = stages(WIDTH, ROWS_PER_STAGE);
  localparam int R      = ROWS_PER_STAGE;

  // sum: running partial sum aligned to the next row still to be evaluated.
  // lo : product bits finished so far (bit j written by row j).
  typedef struct packed {
    logic             vld;
    logic             sgn;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] lo;
  } stage_t;

  // Register 0 captures raw operands; register s (1..STAGES) holds results of rows
  // up to s*R-1; register STAGES is the output register.
  stage_t st_q [STAGES+1];
  stage_t st_d [STAGES+1];
  stage_t calc [1:STAGES];

  logic             adv;
  logic [WIDTH:0]   row_sum_i [WIDTH];
  logic [WIDTH:0]   row_sum_o [WIDTH];
  logic [WIDTH-1:0] row_bit;

  assign adv       = !st_q[STAGES].vld | out_ready;
  assign in_ready  = adv;
  assign out_valid = st_q[STAGES].vld;
  assign out_tag   = st_q[STAGES].tag;
  // Signed mode folds the 2^(2N-1) correction term in by flipping the top product bit.
  assign out_prod  = {st_q[STAGES].sum[WIDTH-1] ^ st_q[STAGES].sgn,
                      st_q[STAGES].sum[WIDTH-2:0], st_q[STAGES].lo};

  for (genvar j = 0; j < WIDTH; j++) begin : g_row
    localparam int S = j / R;
    if (j % R == 0) begin : g_first
      assign row_sum_i[j] = st_q[S].sum;
    end else begin : g_chain
      assign row_sum_i[j] = row_sum_o[j-1];
    end

    arrmul_row #(.WIDTH(WIDTH)) u_row (
      .a_i          (st_q[S].a),
      .b_i          (st_q[S].b[j]),
      .signed_i     (st_q[S].sgn),
      .is_last_row_i(j == WIDTH - 1),
      .sum_i        (row_sum_i[j]),
      .sum_o        (row_sum_o[j]),
      .pbit_o       (row_bit[j])
    );
  end

  // Result of each stage's rows, as it would be registered into the following stage.
  always_comb begin
    for (int s = 1; s <= STAGES; s++) begin
      calc[s] = st_q[s-1];
    end
    for (int j = 0; j < WIDTH; j++) begin
      calc[j/R+1].lo[j] = row_bit[j];
      if ((j % R == R - 1) || (j == WIDTH - 1)) begin
        calc[j/R+1].sum = row_sum_o[j];
      end
    end
  end

  // Data fields load only alongside a valid op so idle-bus X never enters the pipe.
  always_comb begin
    for (int s = 0; s <= STAGES; s++) begin
      st_d[s] = st_q[s];
    end
    if (adv) begin
      st_d[0].vld = in_valid;
      if (in_valid) begin
        st_d[0].sgn = in_signed;
        st_d[0].tag = in_tag;
        st_d[0].a   = in_a;
        st_d[0].b   = in_b;
        st_d[0].lo  = '0;
        // Baugh-Wooley constant 1 at column WIDTH, seeded into the initial sum.
        st_d[0].sum = (in_signed == MODE_SIGNED) ? {1'b1, {WIDTH{1'b0}}} : '0;
      end
      for (int s = 1; s <= STAGES; s++) begin
        if (st_q[s-1].vld) begin
          st_d[s] = calc[s];
        end else begin
          st_d[s].vld = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s <= STAGES; s++) begin
        st_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s <= STAGES; s++) begin
        st_q[s] <= st_d[s];
      end
    end
  end

endmodule

// File: tb/tb_pipe_s_u_arrmul.sv
module tb_pipe_s_u_arrmul;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, in_signed, out_valid, out_ready;
  logic [7:0]  in_a, in_b;
  logic [3:0]  in_tag, out_tag;
  logic [15:0] out_prod;

  logic       v4, r4, s4, ov4;
  logic [3:0] a4, b4, t4, ot4;
  logic [7:0] p4;
  logic       v5, r5, s5, ov5;
  logic [4:0] a5, b5;
  logic [3:0] t5, ot5;
  logic [9:0] p5;

  typedef struct {
    logic [15:0] p;
    logic [3:0]  tag;
    int          edge_c;
  } ent_t;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sg;
    logic [15:0] ex;
  } vec_t;

  ent_t sb[$];
  ent_t q4[$];
  ent_t q5[$];
  vec_t tbl[12];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int xfer = 0;
  bit chk_lat = 0;

  pipe_s_u_arrmul dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod), .out_tag(out_tag)
  );

  pipe_s_u_arrmul #(.WIDTH(4), .ROWS_PER_STAGE(1), .TAG_W(4)) d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4),
    .in_a(a4), .in_b(b4), .in_signed(s4), .in_tag(t4),
    .out_valid(ov4), .out_ready(1'b1), .out_prod(p4), .out_tag(ot4)
  );

  pipe_s_u_arrmul #(.WIDTH(5), .ROWS_PER_STAGE(2), .TAG_W(4)) d5 (
    .clk(clk), .rst_n(rst_n), .in_valid(v5), .in_ready(r5),
    .in_a(a5), .in_b(b5), .in_signed(s5), .in_tag(t5),
    .out_valid(ov5), .out_ready(1'b1), .out_prod(p5), .out_tag(ot5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Behavioural reference: exact product of w-bit operands, truncated to 2w bits.
  function automatic logic [15:0] model(input int w, input int a, input int b, input bit sg);
    longint sa, sbv, p, mask;
    sa  = a;
    sbv = b;
    if (sg && a >= (1 << (w - 1))) sa  = a - (1 << w);
    if (sg && b >= (1 << (w - 1))) sbv = b - (1 << w);
    p    = sa * sbv;
    mask = (longint'(1) << (2 * w)) - 1;
    return 16'(p & mask);
  endfunction

  // Called at posedge+1; returns at posedge+1 after the op was accepted.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic sg,
                      input logic [3:0] tg, input logic [15:0] ex);
    int   n;
    ent_t e;
    in_valid = 1'b1; in_a = a; in_b = b; in_signed = sg; in_tag = tg;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
    end
    e.p = ex; e.tag = tg; e.edge_c = cyc + 1;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = 'x; in_b = 'x; in_signed = 'x; in_tag = 'x;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  // Main DUT scoreboard: the head entry must be on the outputs whenever out_valid is high,
  // including every stalled cycle.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_out: got out_valid=1 prod=%0h, required out_valid=0", out_prod);
      end else begin
        chk("prod", 32'(out_prod), 32'(sb[0].p));
        chk("tag", 32'(out_tag), 32'(sb[0].tag));
        if (out_ready) begin
          if (chk_lat) chk("latency", cyc - sb[0].edge_c, 4);
          void'(sb.pop_front());
          xfer++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov4) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL w4_spurious: got out_valid=1, required 0");
      end else begin
        chk("w4_prod", 32'(p4), 32'(q4[0].p));
        chk("w4_tag", 32'(ot4), 32'(q4[0].tag));
        chk("w4_latency", cyc - q4[0].edge_c, 4);
        chk("w4_in_ready", 32'(r4), 1);
        void'(q4.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov5) begin
      if (q5.size() == 0) begin
        checks++; errors++;
        $display("FAIL w5_spurious: got out_valid=1, required 0");
      end else begin
        chk("w5_prod", 32'(p5), 32'(q5[0].p));
        chk("w5_tag", 32'(ot5), 32'(q5[0].tag));
        chk("w5_latency", cyc - q5[0].edge_c, 3);
        chk("w5_in_ready", 32'(r5), 1);
        void'(q5.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0;
    int n;
    ent_t e;

    tbl[0]  = '{8'h80, 8'h80, 1'b1, 16'h4000};
    tbl[1]  = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
    tbl[2]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    tbl[3]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
    tbl[4]  = '{8'h03, 8'h05, 1'b0, 16'h000F};
    tbl[5]  = '{8'h7F, 8'h80, 1'b1, 16'hC080};
    tbl[6]  = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
    tbl[7]  = '{8'h85, 8'h03, 1'b1, 16'hFE8F};
    tbl[8]  = '{8'h85, 8'h03, 1'b0, 16'h018F};
    tbl[9]  = '{8'h00, 8'h80, 1'b1, 16'h0000};
    tbl[10] = '{8'h80, 8'h7F, 1'b0, 16'h3F80};
    tbl[11] = '{8'hFF, 8'h80, 1'b1, 16'h0080};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_signed = 1'b0; in_tag = '0;
    v4 = 1'b0; a4 = '0; b4 = '0; s4 = 1'b0; t4 = '0;
    v5 = 1'b0; a5 = '0; b5 = '0; s5 = 1'b0; t5 = '0;

    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_prod", 32'(out_prod), 0);
    chk("rst_out_tag", 32'(out_tag), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 32'(in_ready), 1);
    chk("rel_out_valid", 32'(out_valid), 0);
    @(posedge clk); #1;

    // Directed table, one op at a time, latency checked
    chk_lat = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].sg, 4'(i), tbl[i].ex);
      drain();
    end

    // Same operands unsigned then signed, back-to-back
    send(8'hFF, 8'hFF, 1'b0, 4'hA, 16'hFE01);
    send(8'hFF, 8'hFF, 1'b1, 4'hB, 16'h0001);
    drain();

    // in_valid every other cycle
    x0 = xfer;
    for (int i = 0; i < 6; i++) begin
      send(8'(i * 29 + 3), 8'(i * 51 + 7), 1'(i % 2), 4'(i), model(8, (i * 29 + 3) % 256, (i * 51 + 7) % 256, 1'(i % 2)));
      @(posedge clk); #1;
    end
    drain();
    chk("toggle_count", xfer - x0, 6);

    // 8-op stream with a 3-cycle output stall mid-stream
    chk_lat = 1'b0;
    x0 = xfer;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send(8'(i * 37 + 5), 8'(200 - i * 13), 1'(i % 2), 4'(i),
               model(8, (i * 37 + 5) % 256, (200 - i * 13) % 256, 1'(i % 2)));
        end
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(in_ready), 0);
          chk("stall_out_valid", 32'(out_valid), 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stream_count", xfer - x0, 8);

    // Asynchronous reset with ops in flight
    out_ready = 1'b0;
    send(8'h12, 8'h34, 1'b0, 4'hC, model(8, 'h12, 'h34, 1'b0));
    send(8'h9A, 8'h56, 1'b1, 4'hD, model(8, 'h9A, 'h56, 1'b1));
    send(8'hF0, 8'h0F, 1'b0, 4'hE, model(8, 'hF0, 'h0F, 1'b0));
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_out_prod", 32'(out_prod), 0);
    chk("arst_out_tag", 32'(out_tag), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    sb.delete();
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("no_stale_out", 32'(out_valid), 0);
    end
    @(posedge clk); #1;
    chk_lat = 1'b1;
    send(8'h03, 8'h05, 1'b0, 4'h9, 16'h000F);
    drain();

    // Exhaustive small widths, both modes; WIDTH=4 sees bubbles when operands exceed 4 bits
    for (int sg = 0; sg < 2; sg++) begin
      for (int a = 0; a < 32; a++) begin
        for (int b = 0; b < 32; b++) begin
          v5 = 1'b1; a5 = 5'(a); b5 = 5'(b); s5 = 1'(sg); t5 = 4'(a ^ b);
          e.p = model(5, a, b, 1'(sg)); e.tag = 4'(a ^ b); e.edge_c = cyc + 1;
          q5.push_back(e);
          if (a < 16 && b < 16) begin
            v4 = 1'b1; a4 = 4'(a); b4 = 4'(b); s4 = 1'(sg); t4 = 4'(a + b);
            e.p = model(4, a, b, 1'(sg)); e.tag = 4'(a + b); e.edge_c = cyc + 1;
            q4.push_back(e);
          end else begin
            v4 = 1'b0; a4 = 'x; b4 = 'x; s4 = 'x; t4 = 'x;
          end
          @(posedge clk); #1;
        end
      end
    end
    v4 = 1'b0; v5 = 1'b0;
    n = 0;
    while ((q4.size() != 0 || q5.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("w4_drain", q4.size(), 0);
    chk("w5_drain", q5.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
